// File: rtl/multi_voice_tone_gen.sv
// rtl/multi_voice_tone_gen.sv - N-voice timed note player with per-note volume, OR-mixed beeper
module multi_voice_tone_gen #(
  parameter int NUM_CH  = 2,
  parameter int DUR_W   = 24,
  parameter int VOL_W   = 3,
  parameter int GAP_CYC = 12000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    play_enable,
  input  logic                    stop,
  input  logic [NUM_CH-1:0]       note_valid,
  output logic [NUM_CH-1:0]       note_ready,
  input  logic [8*NUM_CH-1:0]     note_code,
  input  logic [DUR_W*NUM_CH-1:0] note_dur,
  input  logic [VOL_W*NUM_CH-1:0] note_vol,
  output logic [NUM_CH-1:0]       tone_out,
  output logic [NUM_CH-1:0]       ch_active,
  output logic [NUM_CH-1:0]       note_done,
  output logic                    beeper
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

  function automatic logic [15:0] period_of(input logic [7:0] code);
    case (code)
      8'd1:    period_of = 16'd45872;
      8'd2:    period_of = 16'd40858;
      8'd3:    period_of = 16'd36408;
      8'd4:    period_of = 16'd34364;
      8'd5:    period_of = 16'd30612;
      8'd6:    period_of = 16'd27273;
      8'd7:    period_of = 16'd24296;
      8'd8:    period_of = 16'd22931;
      8'd9:    period_of = 16'd20432;
      8'd10:   period_of = 16'd18201;
      8'd11:   period_of = 16'd17180;
      8'd12:   period_of = 16'd15306;
      8'd13:   period_of = 16'd13636;
      8'd14:   period_of = 16'd12148;
      8'd15:   period_of = 16'd11478;
      8'd16:   period_of = 16'd10215;
      8'd17:   period_of = 16'd9108;
      8'd18:   period_of = 16'd8593;
      8'd19:   period_of = 16'd7653;
      default: period_of = 16'd0;
    endcase
  endfunction

  logic [NUM_CH-1:0] t;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    state_t             state_q, state_d;
    logic [7:0]         code_q, code_in;
    logic [VOL_W-1:0]   vol_q, vol_in;
    logic [DUR_W-1:0]   dur_cnt, dur_in;
    logic [15:0]        cnt, period, half, duty;
    logic [15+VOL_W:0]  prod;
    logic [GAP_W-1:0]   gap_cnt;
    logic               accept, gap_last, tone_q, done_q;

    assign code_in = note_code[8*c +: 8];
    assign vol_in  = note_vol[VOL_W*c +: VOL_W];
    assign dur_in  = note_dur[DUR_W*c +: DUR_W];

    // Full-width product so low volumes keep their resolution before the scale-down shift
    assign period = period_of(code_q);
    assign half   = {1'b0, period[15:1]};
    assign prod   = (16+VOL_W)'(half) * (16+VOL_W)'(vol_q);
    assign duty   = (&vol_q) ? half : 16'(prod >> VOL_W);
    assign t[c]   = (state_q == PLAY) && (period != 16'd0) && (vol_q != '0) && (cnt < duty);

    assign gap_last = (gap_cnt == GAP_W'(GAP_CYC - 1));

    always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      unique case (state_q)
        IDLE: if (note_valid[c]) begin
          accept  = 1'b1;
          state_d = (dur_in == '0) ? GAP : PLAY;
        end
        PLAY: if (play_enable && dur_cnt == DUR_W'(1)) state_d = GAP;
        GAP:  if (play_enable && gap_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (stop) begin
        state_d = IDLE;
        accept  = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        code_q  <= '0;
        vol_q   <= '0;
        dur_cnt <= '0;
        cnt     <= '0;
        gap_cnt <= '0;
        tone_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        tone_q  <= play_enable & t[c] & ~stop;
        done_q  <= 1'b0;
        if (stop) begin
          dur_cnt <= '0;
          cnt     <= '0;
          gap_cnt <= '0;
        end else if (accept) begin
          code_q  <= code_in;
          vol_q   <= vol_in;
          dur_cnt <= dur_in;
          cnt     <= '0;
          gap_cnt <= '0;
        end else if (play_enable) begin
          if (state_q == PLAY) begin
            dur_cnt <= dur_cnt - 1'b1;
            cnt     <= (period == 16'd0 || cnt == period - 16'd1) ? 16'd0 : cnt + 16'd1;
          end else if (state_q == GAP) begin
            gap_cnt <= gap_last ? '0 : gap_cnt + 1'b1;
            done_q  <= gap_last;
          end
        end
      end
    end

    assign note_ready[c] = (state_q == IDLE);
    assign ch_active[c]  = (state_q == PLAY);
    assign tone_out[c]   = tone_q;
    assign note_done[c]  = done_q;
  end

  // Mixed from the pre-register tone vector so the pin lines up with tone_out
  always_ff @(posedge clk) begin
    if (!rst_n || stop || !play_enable) beeper <= 1'b0;
    else                                beeper <= |t;
  end

endmodule

// File: tb/tb_multi_voice_tone_gen.sv
// tb/tb_multi_voice_tone_gen.sv - randomized bench for multi_voice_tone_gen against an elapsed-time model
module tb_multi_voice_tone_gen;
  localparam int NCH   = 2;
  localparam int DUR_W = 24;
  localparam int VOL_W = 3;
  localparam int GAP   = 64;
  localparam int VMAX  = (1 << VOL_W) - 1;
  localparam int unsigned PER_TAB [0:19] = '{0, 45872, 40858, 36408, 34364, 30612, 27273,
    24296, 22931, 20432, 18201, 17180, 15306, 13636, 12148, 11478, 10215, 9108, 8593, 7653};

  logic clk = 1'b0;
  logic rst_n, play_enable, stop, beeper;
  logic [NCH-1:0] note_valid, note_ready, tone_out, ch_active, note_done;
  logic [8*NCH-1:0] note_code;
  logic [DUR_W*NCH-1:0] note_dur;
  logic [VOL_W*NCH-1:0] note_vol;

  multi_voice_tone_gen #(.NUM_CH(NCH), .DUR_W(DUR_W), .VOL_W(VOL_W), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .play_enable(play_enable), .stop(stop),
    .note_valid(note_valid), .note_ready(note_ready), .note_code(note_code),
    .note_dur(note_dur), .note_vol(note_vol), .tone_out(tone_out),
    .ch_active(ch_active), .note_done(note_done), .beeper(beeper)
  );

  always #5 clk = ~clk;

  // Model: a busy channel is described only by enabled cycles elapsed since its accept edge
  bit          busy [NCH];
  int unsigned kk [NCH], mdur [NCH], mcode [NCH], mvol [NCH];
  int n_checks = 0, n_fail = 0, cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int unsigned period_ref(input int unsigned code);
    return (code < 20) ? PER_TAB[code] : 0;
  endfunction

  function automatic int unsigned duty_ref(input int unsigned p, input int unsigned v);
    return (v == VMAX) ? p / 2 : ((p / 2) * v) / (1 << VOL_W);
  endfunction

  task automatic step();
    logic [NCH-1:0] t_pre, e_tone, e_act, e_rdy, e_done;
    int unsigned p;
    for (int c = 0; c < NCH; c++) begin
      p = period_ref(mcode[c]);
      t_pre[c] = busy[c] && kk[c] < mdur[c] && p != 0 && mvol[c] != 0 &&
                 (kk[c] % p) < duty_ref(p, mvol[c]);
    end
    e_done = '0;
    if (!rst_n || stop) begin
      e_tone = '0;
      for (int c = 0; c < NCH; c++) busy[c] = 1'b0;
    end else begin
      e_tone = play_enable ? t_pre : '0;
      for (int c = 0; c < NCH; c++) begin
        if (!busy[c]) begin
          if (note_valid[c]) begin
            busy[c]  = 1'b1;
            kk[c]    = 0;
            mcode[c] = note_code[8*c +: 8];
            mvol[c]  = note_vol[VOL_W*c +: VOL_W];
            mdur[c]  = note_dur[DUR_W*c +: DUR_W];
          end
        end else if (play_enable) begin
          kk[c]++;
          if (kk[c] == mdur[c] + GAP) begin
            busy[c]   = 1'b0;
            e_done[c] = 1'b1;
          end
        end
      end
    end
    for (int c = 0; c < NCH; c++) begin
      e_act[c] = busy[c] && kk[c] < mdur[c];
      e_rdy[c] = !busy[c];
    end
    @(posedge clk);
    #1;
    cyc++;
    check_eq("tone_out",  32'(tone_out),   32'(e_tone));
    check_eq("ch_active", 32'(ch_active),  32'(e_act));
    check_eq("note_ready", 32'(note_ready), 32'(e_rdy));
    check_eq("note_done", 32'(note_done),  32'(e_done));
    check_eq("beeper",    32'(beeper),     32'(|e_tone));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input int c, input int code, input int vol, input int dur);
    note_valid[c] = 1'b1;
    note_code[8*c +: 8] = 8'(code);
    note_vol[VOL_W*c +: VOL_W] = VOL_W'(vol);
    note_dur[DUR_W*c +: DUR_W] = DUR_W'(dur);
  endtask

  task automatic send();
    step();
    note_valid = '0;
  endtask

  initial begin
    bit paused;
    rst_n = 1'b0; play_enable = 1'b1; stop = 1'b0;
    note_valid = '0; note_code = '0; note_dur = '0; note_vol = '0;
    for (int c = 0; c < NCH; c++) begin
      busy[c] = 1'b0; kk[c] = 0; mdur[c] = 0; mcode[c] = 0; mvol[c] = 0;
    end
    run(2);
    rst_n = 1'b1;
    run(2);

    issue(0, 13, 7, 15000); issue(1, 19, 2, 9000); send(); run(15000 + GAP + 4);
    issue(0, 13, 2, 14000); issue(1, 13, 0, 300);  send(); run(14000 + GAP + 4);
    issue(0, 0, 5, 500);    issue(1, 25, 7, 500);  send(); run(500 + GAP + 4);
    issue(0, 1, 7, 0);      send(); run(GAP + 4);

    issue(0, 13, 3, 8000); issue(1, 1, 7, 3000); send(); run(2000);
    play_enable = 1'b0; run(1000); play_enable = 1'b1; run(6000 + GAP + 4);

    issue(0, 19, 7, 5000); send(); run(100);
    stop = 1'b1; issue(1, 19, 7, 100); issue(0, 13, 7, 100); step();
    stop = 1'b0; note_valid = '0; run(200);

    issue(0, 19, 7, 5000); issue(1, 12, 4, 5000); send(); run(300);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    issue(0, 13, 7, 2000); send(); run(2000 + GAP + 4);

    paused = 1'b0;
    for (int i = 0; i < 16000; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 31) == 0)
          issue(c, $urandom_range(0, 31), $urandom_range(0, VMAX), $urandom_range(0, 2500));
        else
          note_valid[c] = 1'b0;
      end
      if ($urandom_range(0, 199) == 0) paused = ~paused;
      play_enable = ~paused;
      stop  = ($urandom_range(0, 2999) == 0);
      rst_n = ($urandom_range(0, 5999) != 0);
      step();
    end
    note_valid = '0; play_enable = 1'b1; stop = 1'b0; rst_n = 1'b1;
    run(2600 + GAP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
